// File: rtl/mem_arb_pkg.sv
//------------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the two-requester memory arbiter: the arbiter state
// encoding and the owner identifiers used by the picker and the top level.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package mem_arb_pkg;

  // Arbiter control states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } arbState_t;

  // Owner identifiers; the owner and last-grant flags are single bits
  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_LD  = 1'b1;

endpackage : mem_arb_pkg

`default_nettype wire

// File: rtl/mem_arbiter_if.sv
//------------------------------------------------------------------------------
// mem_arbiter_if
// Bundles the CPU requester port, the loader requester port, the shared
// single-port memory bus and the status outputs of mem_arbiter.
// slave  : arbiter side
// master : requesters + memory side (testbench / system)
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface mem_arbiter_if #(
  parameter int DW = 32,
  parameter int AW = 32
);

  // CPU requester
  logic          cpuReq;
  logic          cpuWe;
  logic [AW-1:0] cpuAddr;
  logic [DW-1:0] cpuWData;
  logic          cpuAck;
  logic [DW-1:0] cpuRData;

  // Loader requester
  logic          ldReq;
  logic          ldWe;
  logic [AW-1:0] ldAddr;
  logic [DW-1:0] ldWData;
  logic          ldAck;
  logic [DW-1:0] ldRData;

  // Shared memory
  logic [AW-1:0] memAddr;
  logic          memWe;
  logic [DW-1:0] memDIn;
  logic [DW-1:0] memDOut;

  // Status
  logic          busy;
  logic          owner;

  modport slave (
    input  cpuReq, cpuWe, cpuAddr, cpuWData,
    output cpuAck, cpuRData,
    input  ldReq, ldWe, ldAddr, ldWData,
    output ldAck, ldRData,
    output memAddr, memWe, memDIn,
    input  memDOut,
    output busy, owner
  );

  modport master (
    output cpuReq, cpuWe, cpuAddr, cpuWData,
    input  cpuAck, cpuRData,
    output ldReq, ldWe, ldAddr, ldWData,
    input  ldAck, ldRData,
    input  memAddr, memWe, memDIn,
    output memDOut,
    input  busy, owner
  );

endinterface : mem_arbiter_if

`default_nettype wire

// File: rtl/mem_arb_pick.sv
//------------------------------------------------------------------------------
// mem_arb_pick
// Combinational grantee selection over the two requests. A lone request wins
// outright; on a tie the side that did NOT win last time is chosen. Holding
// i_lastGrant at OWN_LD therefore yields plain CPU-first fixed priority.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic i_cpuReq,
  input  logic i_ldReq,
  input  logic i_lastGrant,
  output logic o_anyReq,
  output logic o_grant
);

  // Loader wins when alone, or on a tie when the CPU was granted last
  always_comb begin
    o_anyReq = i_cpuReq | i_ldReq;
    o_grant  = OWN_CPU;
    if (i_ldReq && (!i_cpuReq || (i_lastGrant == OWN_CPU))) begin
      o_grant = OWN_LD;
    end
  end

endmodule : mem_arb_pick

`default_nettype wire

// File: rtl/mem_arbiter.sv
//------------------------------------------------------------------------------
// mem_arbiter
// Two-requester (CPU, loader) arbiter in front of a single-port memory.
// IDLE -> ACCESS (LAT cycles) -> ACK (one cycle) -> IDLE. The request is
// latched in IDLE, the memory sees one write pulse in the first ACCESS cycle
// and its read data is captured in the last ACCESS cycle.
// Build option: MEM_ARBITER_RR_EN - round-robin on simultaneous requests;
//               undefined gives fixed CPU-first priority.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DW  = 32,
  parameter int AW  = 32,
  parameter int LAT = 1
)(
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  bus
);

  // LAT is limited to 1..15, so the access counter fits in four bits
  localparam logic [3:0] c_lat = 4'(LAT);

  arbState_t     r_state;
  logic [3:0]    r_cnt;
  logic [AW-1:0] r_memAddr;
  logic [DW-1:0] r_memDIn;
  logic [DW-1:0] r_rdata;
  logic          r_memWe;
  logic          r_cpuAck;
  logic          r_ldAck;
  logic          r_busy;
  logic          r_owner;

  logic          w_anyReq;
  logic          w_grant;
  logic          w_lastGrant;

`ifdef MEM_ARBITER_RR_EN
  logic          r_lastGrant;

  // Remember the most recent grantee; loader after reset so the CPU wins the first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lastGrant <= OWN_LD;
    end else if ((r_state == IDLE) && w_anyReq) begin
      r_lastGrant <= w_grant;
    end
  end

  assign w_lastGrant = r_lastGrant;
`else
  // A permanently "loader granted last" view makes the picker CPU-first
  assign w_lastGrant = OWN_LD;
`endif

  mem_arb_pick u_pick (
    .i_cpuReq    (bus.cpuReq),
    .i_ldReq     (bus.ldReq),
    .i_lastGrant (w_lastGrant),
    .o_anyReq    (w_anyReq),
    .o_grant     (w_grant)
  );

  // Control FSM with registered outputs; arbitration only happens in IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= 4'd0;
      r_memAddr <= '0;
      r_memDIn  <= '0;
      r_rdata   <= '0;
      r_memWe   <= 1'b0;
      r_cpuAck  <= 1'b0;
      r_ldAck   <= 1'b0;
      r_busy    <= 1'b0;
      r_owner   <= OWN_CPU;
    end else begin
      // Pulses default low; they are raised for exactly one cycle below
      r_memWe  <= 1'b0;
      r_cpuAck <= 1'b0;
      r_ldAck  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_anyReq) begin
            r_state <= ACCESS;
            r_busy  <= 1'b1;
            r_owner <= w_grant;
            r_cnt   <= c_lat;
            if (w_grant == OWN_LD) begin
              r_memAddr <= bus.ldAddr;
              r_memDIn  <= bus.ldWData;
              r_memWe   <= bus.ldWe;
            end else begin
              r_memAddr <= bus.cpuAddr;
              r_memDIn  <= bus.cpuWData;
              r_memWe   <= bus.cpuWe;
            end
          end
        end
        ACCESS: begin
          r_cnt <= r_cnt - 4'd1;
          // Last access cycle: capture memory output (also for writes) and ack the owner
          if (r_cnt == 4'd1) begin
            r_state  <= ACK;
            r_rdata  <= bus.memDOut;
            r_cpuAck <= (r_owner == OWN_CPU);
            r_ldAck  <= (r_owner == OWN_LD);
          end
        end
        ACK: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.memAddr  = r_memAddr;
  assign bus.memDIn   = r_memDIn;
  assign bus.memWe    = r_memWe;
  assign bus.cpuAck   = r_cpuAck;
  assign bus.ldAck    = r_ldAck;
  assign bus.cpuRData = r_rdata;
  assign bus.ldRData  = r_rdata;
  assign bus.busy     = r_busy;
  assign bus.owner    = r_owner;

endmodule : mem_arbiter

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
//------------------------------------------------------------------------------
// tb_mem_arbiter
// Self-checking bench for mem_arbiter with LAT=2. A word memory with
// combinational read and clocked write sits on the memory bus; a
// transaction-level model (shadow memory + last-grant flag) predicts grantee,
// read data and timing for directed and random transactions.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int LAT = 2;

  logic clk;
  logic rst_n;

  int checks   = 0;
  int failures = 0;

  mem_arbiter_if #(.DW(DW), .AW(AW)) bus ();

  mem_arbiter #(.DW(DW), .AW(AW), .LAT(LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Power-up content of every memory word
  function automatic logic [31:0] initVal(input logic [7:0] i);
    if (i == 8'd4) return 32'hDEADBEEF;
    return {i, ~i, i ^ 8'h5A, 8'hC3};
  endfunction

  // Bench memory: unwritten words read their power-up value
  bit [31:0] memStore [256];
  bit        memWr    [256];
  wire [7:0] memIdx = bus.memAddr[9:2];

  assign bus.memDOut = memWr[memIdx] ? memStore[memIdx] : initVal(memIdx);

  always @(posedge clk) begin
    if (bus.memWe === 1'b1) begin
      memStore[memIdx] <= bus.memDIn;
      memWr[memIdx]    <= 1'b1;
    end
  end

  // Reference model state
  logic [31:0] refMem [256];
  logic        mLast;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rndAddr();
    return {22'd0, 8'($urandom_range(0, 15)), 2'b00};
  endfunction

  // One transaction starting at a negedge with the arbiter idle
  task automatic runTxn(input bit cR, input bit cW, input logic [31:0] cA, input logic [31:0] cD,
                        input bit lR, input bit lW, input logic [31:0] lA, input logic [31:0] lD,
                        input bit dropEarly);
    logic        g;
    logic        gW;
    logic [31:0] gA;
    logic [31:0] gD;
    logic [31:0] expR;
    logic [7:0]  wi;
    bus.cpuReq = cR; bus.cpuWe = cW; bus.cpuAddr = cA; bus.cpuWData = cD;
    bus.ldReq  = lR; bus.ldWe  = lW; bus.ldAddr  = lA; bus.ldWData  = lD;
    if (cR && lR) begin
`ifdef MEM_ARBITER_RR_EN
      g = (mLast == OWN_CPU) ? OWN_LD : OWN_CPU;
`else
      g = OWN_CPU;
`endif
    end else begin
      g = lR ? OWN_LD : OWN_CPU;
    end
    gW = g ? lW : cW;
    gA = g ? lA : cA;
    gD = g ? lD : cD;
    wi = gA[9:2];
    // Write lands after the first access cycle, so a later capture sees it
    expR = (gW && LAT > 1) ? gD : refMem[wi];
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      chk("accBusy",   bus.busy,    1);
      chk("accWe",     bus.memWe,   (k == 1) ? gW : 1'b0);
      chk("accAddr",   bus.memAddr, gA);
      chk("accDIn",    bus.memDIn,  gD);
      chk("accOwner",  bus.owner,   g);
      chk("accCpuAck", bus.cpuAck,  0);
      chk("accLdAck",  bus.ldAck,   0);
      if (dropEarly && k == 1) begin
        if (g == OWN_CPU) bus.cpuReq = 1'b0;
        else              bus.ldReq  = 1'b0;
      end
    end
    @(negedge clk);
    chk("ackCpu",  bus.cpuAck, (g == OWN_CPU));
    chk("ackLd",   bus.ldAck,  (g == OWN_LD));
    chk("ackData", g ? bus.ldRData : bus.cpuRData, expR);
    chk("ackBusy", bus.busy, 1);
    chk("ackWe",   bus.memWe, 0);
    if (g == OWN_CPU) bus.cpuReq = 1'b0;
    else              bus.ldReq  = 1'b0;
    if (gW) refMem[wi] = gD;
    mLast = g;
    @(negedge clk);
    chk("idleBusy",   bus.busy,    0);
    chk("idleCpuAck", bus.cpuAck,  0);
    chk("idleLdAck",  bus.ldAck,   0);
    chk("idleWe",     bus.memWe,   0);
    chk("idleAddr",   bus.memAddr, gA);
    chk("idleData",   g ? bus.ldRData : bus.cpuRData, expR);
  endtask

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int sel;
    for (int i = 0; i < 256; i++) refMem[i] = initVal(8'(i));
    mLast = OWN_LD;
    rst_n = 1'b0;
    bus.cpuReq = 1'b0; bus.cpuWe = 1'b0; bus.cpuAddr = '0; bus.cpuWData = '0;
    bus.ldReq  = 1'b0; bus.ldWe  = 1'b0; bus.ldAddr  = '0; bus.ldWData  = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rstBusy",   bus.busy,     0);
    chk("rstWe",     bus.memWe,    0);
    chk("rstCpuAck", bus.cpuAck,   0);
    chk("rstLdAck",  bus.ldAck,    0);
    chk("rstOwner",  bus.owner,    0);
    chk("rstAddr",   bus.memAddr,  0);
    chk("rstDIn",    bus.memDIn,   0);
    chk("rstRData",  bus.cpuRData, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("postRstBusy", bus.busy, 0);

    // CPU read of the preloaded word
    runTxn(1, 0, 32'h10, 32'h0, 0, 0, 32'h0, 32'h0, 0);
    // Loader write then CPU read-back
    runTxn(0, 0, 32'h0, 32'h0, 1, 1, 32'h20, 32'h12345678, 0);
    runTxn(1, 0, 32'h20, 32'h0, 0, 0, 32'h0, 32'h0, 0);
    // Contention for three grants (right after reset the CPU wins the tie)
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    mLast = OWN_LD;
    @(negedge clk);
    for (int n = 0; n < 3; n++) begin
      runTxn(1, 0, 32'h30, 32'h0, 1, 0, 32'h34, 32'h0, 0);
    end
    bus.cpuReq = 1'b0; bus.ldReq = 1'b0;
    // CPU drops its request in the first access cycle
    runTxn(1, 0, 32'h08, 32'h0, 0, 0, 32'h0, 32'h0, 1);

    // Reset during the write pulse
    bus.cpuReq = 1'b1; bus.cpuWe = 1'b1; bus.cpuAddr = 32'h40; bus.cpuWData = 32'hCAFEF00D;
    @(negedge clk);
    chk("wpWe", bus.memWe, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("wpWeDrop", bus.memWe, 0);
    chk("wpBusy",   bus.busy,  0);
    bus.cpuReq = 1'b0; bus.cpuWe = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    mLast = OWN_LD;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      chk("wpIdleBusy",   bus.busy,   0);
      chk("wpNoCpuAck",   bus.cpuAck, 0);
      chk("wpNoLdAck",    bus.ldAck,  0);
    end
    // Discarded write must not have reached memory
    runTxn(1, 0, 32'h40, 32'h0, 0, 0, 32'h0, 32'h0, 0);

    // Random traffic against the model
    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(1, 3);
      runTxn(sel[0], 1'($urandom_range(0, 1)), rndAddr(), $urandom,
             sel[1], 1'($urandom_range(0, 1)), rndAddr(), $urandom,
             ($urandom_range(0, 3) == 0));
    end
    bus.cpuReq = 1'b0; bus.ldReq = 1'b0;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_mem_arbiter

`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DW, default 32, is the data width in bits.
REQ-002 Parameter AW, default 32, is the byte-address width in bits.
REQ-003 Parameter LAT, default 1, is the number of memory access cycles per transaction; legal range is 1..15.
REQ-004 Port clk, input, 1 bit, is the single clock; all state changes on its rising edge.
REQ-005 Port rst_n, input, 1 bit, is the reset; it is asynchronous and active-low.
REQ-006 Port cpuReq, input, 1 bit, is the CPU access request, held high until cpuAck.
REQ-007 Port cpuWe, input, 1 bit, marks the CPU request as a write (1) or a read (0).
REQ-008 Ports cpuAddr (input, AW bits) and cpuWData (input, DW bits) carry the CPU address and write data.
REQ-009 Port cpuAck, output, 1 bit, is a one-cycle completion pulse to the CPU.
REQ-010 Port cpuRData, output, DW bits, is the CPU read data.
REQ-011 Ports ldReq, ldWe, ldAddr, ldWData, ldAck and ldRData form the loader requester port, mirroring the CPU port.
REQ-012 Ports memAddr (output, AW bits), memWe (output, 1 bit) and memDIn (output, DW bits) drive the shared single-port memory.
REQ-013 Port memDOut, input, DW bits, is the memory read data.
REQ-014 Port busy, output, 1 bit, is high while the state is not IDLE.
REQ-015 Port owner, output, 1 bit, identifies the current or last grantee: 0 for CPU, 1 for loader.

Function
REQ-016 The state machine SHALL have three states, IDLE, ACCESS and ACK, with the following transitions: IDLE goes to ACCESS when any request is high; ACCESS goes to ACK when its counter expires; ACK always returns to IDLE.
REQ-017 In IDLE with any request high, the block SHALL choose a grantee, latch that requester's addr, we and wdata, and load the counter with LAT.
REQ-018 ACCESS SHALL last exactly LAT cycles; memAddr and memDIn SHALL show the latched values throughout ACCESS.
REQ-019 memWe SHALL be high only in the first ACCESS cycle of a write, giving exactly one write pulse per write.
REQ-020 In the last ACCESS cycle, the block SHALL capture memDOut into the rdata register for both reads and writes.
REQ-021 In ACK, only the grantee's ack SHALL be high, for one cycle; its RData SHALL be valid in that cycle and held until the next capture.
REQ-022 Ack latency SHALL be LAT+1 cycles after the IDLE cycle that sampled the request; back-to-back throughput SHALL be one access per LAT+2 cycles.
REQ-023 Arbitration SHALL occur only in IDLE; a transaction in flight SHALL never be preempted.
REQ-024 If a requester drops its req during ACCESS, the access SHALL still complete and its ack SHALL still pulse.
REQ-025 The non-grantee's ack SHALL remain 0 at all times; in IDLE, memWe SHALL be 0 and memAddr SHALL hold its last value.

Reset
REQ-026 While rst_n is low, the state SHALL be IDLE, and busy, memWe, cpuAck, ldAck and owner SHALL all be 0.
REQ-027 While rst_n is low, memAddr, memDIn, the rdata register and the counter SHALL all be 0.
REQ-028 When reset is asserted mid-transaction, memWe SHALL drop immediately, the in-flight access SHALL be discarded, and no ack SHALL be issued for it.
REQ-029 After reset, the last-grant flag SHALL equal loader, so that the CPU wins the first tie.

Configuration
REQ-030 Macro MEM_ARBITER_RR_EN, when defined, SHALL make simultaneous requests alternate round-robin against the last-grant flag.
REQ-031 Without MEM_ARBITER_RR_EN, the CPU SHALL always win simultaneous requests (fixed priority); the last-grant flag SHALL be absent.

Structure
REQ-032 Shared package mem_arb_pkg SHALL hold the state encoding (IDLE, ACCESS, ACK) and the owner constants OWN_CPU=0 and OWN_LD=1.
REQ-033 Grantee selection SHALL be one sub-module, mem_arb_pick, which is combinational over the two reqs and the last-grant flag.
REQ-034 The counter, latches and state register SHALL stay in mem_arbiter.

Verification (LAT=2)
REQ-035 Reset: drive rst_n low -> all outputs 0 and busy 0; release rst_n -> state IDLE.
REQ-036 CPU read of 0x10, with the memory word 0xDEADBEEF -> cpuAck 3 cycles after req, cpuRData=0xDEADBEEF, memWe never high.
REQ-037 Loader write of 0x12345678 to 0x20 -> memWe high exactly one cycle with memAddr=0x20 and memDIn=0x12345678; ldAck follows; a subsequent CPU read of 0x20 returns 0x12345678.
REQ-038 Both requesters continuously requesting for 3 grants -> with RR_EN, grants go cpu, ld, cpu; without it, grants go cpu, cpu, cpu and ldAck stays 0.
REQ-039 cpuReq dropped in the first ACCESS cycle -> the access completes and cpuAck still pulses once.
REQ-040 rst_n pulsed low during the write-pulse cycle -> memWe falls with no clock edge; after release, busy=0 and no ack is issued.
